// File: rtl/blinker_pkg.sv
// Shared types for the blinker LED path: pattern modes, bounce direction and reset mode.
package blinker_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam mode_e RESET_MODE = MODE_TOGGLE;

endpackage : blinker_pkg

// File: rtl/blinker_tick_prescaler.sv
// Divides accepted ticks by div_i+1; fire_c_o marks the tick that completes a period.
module blinker_tick_prescaler #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             fire_c_o
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic             at_limit;

  // >= rather than == so a divisor shrunk below the count still fires next tick
  assign at_limit = (count_q >= div_i);
  assign fire_c_o = accept_i & ~clear_i & at_limit;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (accept_i) begin
      count_d = at_limit ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : blinker_tick_prescaler

// File: rtl/blinker_led_sequencer.sv
// Turns prescaled ticks into LED patterns (hold/toggle/shift/bounce) with step and wrap pulses.
module blinker_led_sequencer
  import blinker_pkg::*;
#(
  parameter int unsigned LED_W = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              tick_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              mode_load_i,
  input  logic              pause_i,
  output logic [LED_W-1:0]  leds_o,
  output logic              step_o,
  output logic              wrap_o
);

  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic             accept;
  logic             fire;
  logic [LED_W-1:0] leds_inv;
  logic [LED_W-1:0] leds_rol;
  logic [LED_W-1:0] leds_shl;
  logic [LED_W-1:0] leds_shr;

  // A mode load swallows any coincident tick
  assign accept = tick_i & ~pause_i & ~mode_load_i;

  blinker_tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (system1000),
    .rst_n    (system1000_rstn),
    .accept_i (accept),
    .clear_i  (mode_load_i),
    .div_i    (div_i),
    .fire_c_o (fire)
  );

  assign leds_inv = ~leds_q;
  assign leds_rol = {leds_q[LED_W-2:0], leds_q[LED_W-1]};
  assign leds_shl = {leds_q[LED_W-2:0], 1'b0};
  assign leds_shr = {1'b0, leds_q[LED_W-1:1]};

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    leds_d = leds_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    if (mode_load_i) begin
      mode_d = mode_e'(mode_i);
      dir_d  = DIR_LEFT;
      unique case (mode_e'(mode_i))
        MODE_HOLD:   leds_d = leds_q;
        MODE_TOGGLE: leds_d = '0;
        default:     leds_d = LED_ONE;
      endcase
    end else if (fire) begin
      step_d = 1'b1;
      unique case (mode_q)
        MODE_HOLD: begin
          leds_d = leds_q;
        end
        MODE_TOGGLE: begin
          leds_d = leds_inv;
          wrap_d = (leds_inv == '0);
        end
        MODE_SHIFT: begin
          leds_d = leds_rol;
          wrap_d = (leds_rol == LED_ONE);
        end
        MODE_BOUNCE: begin
          // Direction flips on the step that lands on an end bit
          if (dir_q == DIR_LEFT) begin
            leds_d = leds_shl;
            if (leds_shl[LED_W-1]) begin
              dir_d  = DIR_RIGHT;
              wrap_d = 1'b1;
            end
          end else begin
            leds_d = leds_shr;
            if (leds_shr == LED_ONE) begin
              dir_d  = DIR_LEFT;
              wrap_d = 1'b1;
            end
          end
        end
        default: leds_d = leds_q;
      endcase
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      mode_q <= RESET_MODE;
      dir_q  <= DIR_LEFT;
      leds_q <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      leds_q <= leds_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign leds_o = leds_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule : blinker_led_sequencer

// File: tb/tb_blinker_led_sequencer.sv
// Directed bench for blinker_led_sequencer: per-cycle reference model feeding an expectation queue.
module tb_blinker_led_sequencer;

  localparam int unsigned LED_W = 8;
  localparam int unsigned DIV_W = 4;

  typedef struct packed {
    logic [LED_W-1:0] leds;
    logic             step;
    logic             wrap;
    logic [DIV_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             tick;
  logic [DIV_W-1:0] div;
  logic [1:0]       mode;
  logic             load;
  logic             pause;
  logic [LED_W-1:0] leds_o;
  logic             step_o;
  logic             wrap_o;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // Reference state
  logic [LED_W-1:0] m_leds;
  logic [DIV_W-1:0] m_cnt;
  logic [1:0]       m_mode;
  logic             m_right;

  blinker_led_sequencer #(
    .LED_W (LED_W),
    .DIV_W (DIV_W)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .tick_i          (tick),
    .div_i           (div),
    .mode_i          (mode),
    .mode_load_i     (load),
    .pause_i         (pause),
    .leds_o          (leds_o),
    .step_o          (step_o),
    .wrap_o          (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_leds  = '0;
    m_cnt   = '0;
    m_mode  = 2'd1;
    m_right = 1'b0;
  endtask

  // Predicts outputs after the coming edge from the currently driven inputs
  task automatic model_push();
    exp_t e;
    e.step = 1'b0;
    e.wrap = 1'b0;
    if (load) begin
      m_mode  = mode;
      m_right = 1'b0;
      m_cnt   = '0;
      if (mode == 2'd1) m_leds = '0;
      else if (mode != 2'd0) m_leds = 8'h01;
    end else if (tick && !pause) begin
      if (m_cnt >= div) begin
        m_cnt  = '0;
        e.step = 1'b1;
        case (m_mode)
          2'd1: begin
            m_leds = ~m_leds;
            e.wrap = (m_leds == 8'h00);
          end
          2'd2: begin
            m_leds = (m_leds << 1) | (m_leds >> 7);
            e.wrap = (m_leds == 8'h01);
          end
          2'd3: begin
            if (!m_right) begin
              m_leds = m_leds << 1;
              if (m_leds == 8'h80) begin m_right = 1'b1; e.wrap = 1'b1; end
            end else begin
              m_leds = m_leds >> 1;
              if (m_leds == 8'h01) begin m_right = 1'b0; e.wrap = 1'b1; end
            end
          end
          default: ;
        endcase
      end else begin
        m_cnt = m_cnt + 4'd1;
      end
    end
    e.leds = m_leds;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic t, input logic l, input logic p);
    exp_t e;
    tick  = t;
    load  = l;
    pause = p;
    model_push();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("leds", 32'(leds_o), 32'(e.leds));
    chk("step", 32'(step_o), 32'(e.step));
    chk("wrap", 32'(wrap_o), 32'(e.wrap));
    chk("count", 32'(dut.u_prescaler.count_q), 32'(e.cnt));
    tick = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    div   = '0;
    mode  = 2'd0;
    load  = 1'b0;
    pause = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", 32'(leds_o), 32'h0);
    chk("rst_step", 32'(step_o), 32'h0);
    chk("rst_wrap", 32'(wrap_o), 32'h0);
    rst_n = 1'b1;

    // Toggle at div 0, tick every cycle
    cyc(1'b1, 1'b0, 1'b0);
    chk("tog_ff", 32'(leds_o), 32'hFF);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tog_00_wrap", 32'(wrap_o), 32'h1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);

    // Shift, div 3, one tick per 10 cycles
    mode = 2'd2;
    div  = 4'd3;
    cyc(1'b0, 1'b1, 1'b0);
    chk("shift_load", 32'(leds_o), 32'h01);
    for (int s = 1; s <= 8; s++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(1'b1, 1'b0, 1'b0);
        if (k == 3) chk("shift_step", 32'(step_o), 32'h1);
        if (k == 3 && s == 1) chk("shift_02", 32'(leds_o), 32'h02);
        if (k == 3 && s == 8) begin
          chk("shift_wrap_leds", 32'(leds_o), 32'h01);
          chk("shift_wrap", 32'(wrap_o), 32'h1);
        end
        for (int j = 0; j < 9; j++) cyc(1'b0, 1'b0, 1'b0);
      end
    end

    // Bounce, div 0, one full period
    mode = 2'd3;
    div  = 4'd0;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == 7) begin
        chk("bounce_80", 32'(leds_o), 32'h80);
        chk("bounce_80_wrap", 32'(wrap_o), 32'h1);
      end
      if (i == 14) begin
        chk("bounce_01", 32'(leds_o), 32'h01);
        chk("bounce_01_wrap", 32'(wrap_o), 32'h1);
      end
    end

    // Pause mid-shift at leds 08, count 2
    mode = 2'd2;
    div  = 4'd3;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_pause_leds", 32'(leds_o), 32'h08);
    chk("pre_pause_cnt", 32'(dut.u_prescaler.count_q), 32'h2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("pause_leds", 32'(leds_o), 32'h08);
    chk("pause_cnt", 32'(dut.u_prescaler.count_q), 32'h2);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("unpause_10", 32'(leds_o), 32'h10);
    chk("unpause_step", 32'(step_o), 32'h1);

    // Load coincident with a tick at count == div
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    mode = 2'd1;
    cyc(1'b1, 1'b1, 1'b0);
    chk("ld_tick_step", 32'(step_o), 32'h0);
    chk("ld_tick_cnt", 32'(dut.u_prescaler.count_q), 32'h0);
    chk("ld_tick_leds", 32'(leds_o), 32'h00);

    // Divisor shrinks below the count
    div = 4'd7;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    div = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("shrink_step", 32'(step_o), 32'h1);
    chk("shrink_cnt", 32'(dut.u_prescaler.count_q), 32'h0);
    chk("shrink_leds", 32'(leds_o), 32'hFF);

    // Asynchronous reset mid-bounce
    mode = 2'd3;
    div  = 4'd0;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("arst_leds", 32'(leds_o), 32'h0);
    chk("arst_step", 32'(step_o), 32'h0);
    chk("arst_wrap", 32'(wrap_o), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("arst_toggle", 32'(leds_o), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_blinker_led_sequencer

// File: doc/blinker_led_sequencer.md
Name: blinker_led_sequencer

Overview:
- Consumer end of the blinker tick interface. It takes the single-cycle terminal-count pulse from the enabled tick counter and turns it into visible LED patterns.
- It prescales incoming ticks by a run-time divisor and steps a pattern state machine. Four modes: HOLD, TOGGLE, SHIFT, BOUNCE.
- It sits between the tick counter and the board LED pins. It also reports a step pulse and a wrap pulse for chaining and status.

Parameters:
- LED_W, 8, number of LED outputs; legal range is 2 or more.
- DIV_W, 4, width of the tick prescale divisor.

Ports:
- system1000  input  1  clock.
- system1000_rstn  input  1  asynchronous reset, active low.
- tick_i  input  1  single-cycle tick pulse from the tick counter; may be high on consecutive cycles.
- div_i  input  DIV_W  pattern advances once every div_i+1 accepted ticks.
- mode_i  input  2  requested mode: 0=HOLD, 1=TOGGLE, 2=SHIFT, 3=BOUNCE.
- mode_load_i  input  1  single-cycle strobe; applies mode_i.
- pause_i  input  1  level; freezes the prescaler and the pattern.
- leds_o  output  LED_W  registered LED pattern.
- step_o  output  1  registered; high for one cycle in the cycle leds_o shows a new step.
- wrap_o  output  1  registered; high together with step_o on a pattern wrap point.

Behaviour:
- Reset (asynchronous, active low, takes effect immediately):
  - mode=TOGGLE, leds_o=0, prescale count=0, direction=LEFT.
  - step_o=0, wrap_o=0.
- Accepted tick: tick_i=1 AND pause_i=0 AND mode_load_i=0.
- Prescaler, on an accepted tick:
  - If count >= div_i: count<=0 and a step fires.
  - Otherwise count<=count+1.
  - The >= compare covers div_i shrinking below the current count: the step fires on the next accepted tick.
  - div_i=0 means a step on every accepted tick.
- Step latency: leds_o, step_o and wrap_o update on the same clock edge that samples the firing tick, so they are visible 1 cycle after tick_i.
- step_o and wrap_o return to 0 on the next cycle unless another step fires.
- mode_load_i (highest priority, beats tick and pause):
  - Latches mode_i and clears the prescale count.
  - Sets direction=LEFT and reloads leds_o: HOLD keeps its current value; TOGGLE gets all zeros; SHIFT and BOUNCE get 1 (bit0).
  - step_o and wrap_o stay 0 on this edge.
  - A tick in the same cycle is discarded.
- Step action per mode:
  - HOLD: leds_o unchanged, step_o=1, wrap_o=0.
  - TOGGLE: leds_o <= ~leds_o. wrap_o=1 when the new value is all zeros.
  - SHIFT: rotate left by one; the MSB wraps to bit0. wrap_o=1 when the new value is 1.
  - BOUNCE, direction LEFT: shift left, zero fill. When the new value has the MSB set, direction<=RIGHT and wrap_o=1.
  - BOUNCE, direction RIGHT: shift right. When the new value is 1, direction<=LEFT and wrap_o=1.
  - BOUNCE period is 2*(LED_W-1) steps.
- Illegal leds_o in BOUNCE or SHIFT (only reachable by a mode change from TOGGLE or HOLD) cannot occur, because the load reinitialises leds_o.
- pause_i=1: the count, leds_o and direction hold. step_o and wrap_o are 0.
- Arithmetic: the prescale count is DIV_W bits unsigned and never exceeds div_i after a step, so there is no overflow path.

Decomposition:
- Shared package blinker_pkg:
  - mode enum (HOLD, TOGGLE, SHIFT, BOUNCE), 2 bits.
  - Direction constants LEFT and RIGHT.
  - Reset-mode constant (TOGGLE).
- Sub-module blinker_tick_prescaler: count register, accept/clear/compare logic, single-cycle fire output.
- Pattern state machine and output registers live in the top.

Test Plan:
- Reset released, tick every cycle, div_i=0 -> leds_o toggles 00,FF,00... one cycle after each tick. wrap_o=1 on each return to 00.
- mode_load SHIFT, div_i=3, one tick every 10 cycles -> leds_o steps 01→02 after the 4th tick; step_o pulses every 40 cycles; after 8 steps leds_o=01 with wrap_o=1.
- mode_load BOUNCE, div_i=0, 14 ticks -> leds_o sequence 02,04,...,80 (wrap),40,...,01 (wrap).
- pause_i high for 5 ticks mid-SHIFT at leds_o=08, count=2 -> leds_o and count hold and step_o=0. After release, the 2nd tick (div_i=3) steps to 10.
- mode_load_i and tick_i in the same cycle, count=div_i -> mode changes and leds_o reloads, with no step pulse and count=0.
- div_i changes from 7 to 1 while count=5 -> next accepted tick steps and clears the count. Reset asserted mid-BOUNCE -> leds_o=0, TOGGLE mode, outputs 0 immediately.
